// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: types and constants shared by the SDRAM port arbiter files.
//   state_e  : arbiter FSM states (IDLE, ISSUE, ACK)
//   owner_t  : requester index, OWN_VGA / OWN_CPU / OWN_DMA
//   RUN_W    : width of the consecutive-VGA-grant run counter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_ACK   = 2'b10
    } state_e;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_VGA = 2'd0;
    localparam owner_t OWN_CPU = 2'd1;
    localparam owner_t OWN_DMA = 2'd2;

    localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: bundles the three requester ports, the pause
// controls, the shared read-data/busy outputs and the downstream memory port.
//   slave  : the arbiter's view (requests in, acks/mem_* out)
//   master : the environment's view (requesters plus memory controller)
interface sdram_port_arbiter_if #(
    parameter int unsigned addr_width = 24
);

    logic                  pausecpu;
    logic                  pausevga;

    logic                  vga_req;
    logic                  vga_wr;
    logic [addr_width-1:0] vga_addr;
    logic [15:0]           vga_wdata;
    logic [1:0]            vga_bytesel;
    logic                  vga_ack;

    logic                  cpu_req;
    logic                  cpu_wr;
    logic [addr_width-1:0] cpu_addr;
    logic [15:0]           cpu_wdata;
    logic [1:0]            cpu_bytesel;
    logic                  cpu_ack;

    logic                  dma_req;
    logic                  dma_wr;
    logic [addr_width-1:0] dma_addr;
    logic [15:0]           dma_wdata;
    logic [1:0]            dma_bytesel;
    logic                  dma_ack;

    logic [15:0]           rdata;
    logic                  busy;

    logic                  mem_req;
    logic                  mem_wr;
    logic [addr_width-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic [1:0]            mem_bytesel;
    logic                  mem_ack;
    logic [15:0]           mem_rdata;

    modport slave (
        input  pausecpu, pausevga,
        input  vga_req, vga_wr, vga_addr, vga_wdata, vga_bytesel,
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_bytesel,
        input  dma_req, dma_wr, dma_addr, dma_wdata, dma_bytesel,
        output vga_ack, cpu_ack, dma_ack,
        output rdata, busy,
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_bytesel,
        input  mem_ack, mem_rdata
    );

    modport master (
        output pausecpu, pausevga,
        output vga_req, vga_wr, vga_addr, vga_wdata, vga_bytesel,
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_bytesel,
        output dma_req, dma_wr, dma_addr, dma_wdata, dma_bytesel,
        input  vga_ack, cpu_ack, dma_ack,
        input  rdata, busy,
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_bytesel,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational winner selection for the SDRAM arbiter.
//   vga/cpu/dma_req_i, pausevga_i, pausecpu_i : raw requests and pauses
//   run_cnt_i, rr_cpu_next_i                  : current run counter / RR pointer
//   grant_o, owner_o                          : an eligible winner exists, and who
//   run_cnt_o                                 : run counter value if this grant is taken
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned vga_max_run = 4
) (
    input  logic             vga_req_i,
    input  logic             cpu_req_i,
    input  logic             dma_req_i,
    input  logic             pausevga_i,
    input  logic             pausecpu_i,
    input  logic [RUN_W-1:0] run_cnt_i,
    input  logic             rr_cpu_next_i,
    output logic             grant_o,
    output owner_t           owner_o,
    output logic [RUN_W-1:0] run_cnt_o
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(vga_max_run);

    logic vga_el;
    logic cpu_el;
    logic dma_el;
    logic other_el;
    logic run_full;

    always_comb begin
        vga_el    = vga_req_i & ~pausevga_i;
        cpu_el    = cpu_req_i & ~pausecpu_i;
        dma_el    = dma_req_i;
        other_el  = cpu_el | dma_el;
        run_full  = (run_cnt_i >= RUN_MAX);

        grant_o   = vga_el | other_el;
        owner_o   = OWN_VGA;
        run_cnt_o = run_cnt_i;

        if (vga_el && !(run_full && other_el)) begin
            owner_o = OWN_VGA;
            // Only VGA grants that make CPU/DMA wait count toward the run;
            // run_full cannot be set here while CPU/DMA is eligible, so the
            // increment never exceeds RUN_MAX.
            run_cnt_o = other_el ? (run_cnt_i + 1'b1) : '0;
        end else if (other_el) begin
            run_cnt_o = '0;
            owner_o   = (cpu_el && (!dma_el || rr_cpu_next_i)) ? OWN_CPU : OWN_DMA;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: three-port (VGA/CPU/DMA) arbiter in front of a single
// SDRAM controller port.
//   clk      : system clock, rising edge
//   reset_in : asynchronous active-low reset
//   bus      : requester ports, pauses, rdata/busy and downstream mem_* port
// A granted request is registered onto mem_* (ISSUE) and held until mem_ack,
// then the owner gets a one-cycle ack (ACK) before returning to IDLE.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned addr_width  = 24,
    parameter int unsigned vga_max_run = 4
) (
    input  logic                 clk,
    input  logic                 reset_in,
    sdram_port_arbiter_if.slave  bus
);

    state_e                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]           mem_wdata_q, mem_wdata_d;
    logic [1:0]            mem_bytesel_q, mem_bytesel_d;
    logic [15:0]           rdata_q, rdata_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic                  rr_cpu_next_q, rr_cpu_next_d;

    logic                  pick_grant;
    owner_t                pick_owner;
    logic [RUN_W-1:0]      pick_run;

    logic                  sel_wr;
    logic [addr_width-1:0] sel_addr;
    logic [15:0]           sel_wdata;
    logic [1:0]            sel_bytesel;

    sdram_arb_pick #(
        .vga_max_run (vga_max_run)
    ) u_pick (
        .vga_req_i     (bus.vga_req),
        .cpu_req_i     (bus.cpu_req),
        .dma_req_i     (bus.dma_req),
        .pausevga_i    (bus.pausevga),
        .pausecpu_i    (bus.pausecpu),
        .run_cnt_i     (run_q),
        .rr_cpu_next_i (rr_cpu_next_q),
        .grant_o       (pick_grant),
        .owner_o       (pick_owner),
        .run_cnt_o     (pick_run)
    );

    always_comb begin
        sel_wr      = bus.vga_wr;
        sel_addr    = bus.vga_addr;
        sel_wdata   = bus.vga_wdata;
        sel_bytesel = bus.vga_bytesel;
        case (pick_owner)
            OWN_CPU: begin
                sel_wr      = bus.cpu_wr;
                sel_addr    = bus.cpu_addr;
                sel_wdata   = bus.cpu_wdata;
                sel_bytesel = bus.cpu_bytesel;
            end
            OWN_DMA: begin
                sel_wr      = bus.dma_wr;
                sel_addr    = bus.dma_addr;
                sel_wdata   = bus.dma_wdata;
                sel_bytesel = bus.dma_bytesel;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_bytesel_d = mem_bytesel_q;
        rdata_d       = rdata_q;
        run_d         = run_q;
        rr_cpu_next_d = rr_cpu_next_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_grant) begin
                    state_d       = ST_ISSUE;
                    owner_d       = pick_owner;
                    mem_req_d     = 1'b1;
                    mem_wr_d      = sel_wr;
                    mem_addr_d    = sel_addr;
                    mem_wdata_d   = sel_wdata;
                    mem_bytesel_d = sel_bytesel;
                    run_d         = pick_run;
                    if (pick_owner == OWN_CPU) begin
                        rr_cpu_next_d = 1'b0;
                    end else if (pick_owner == OWN_DMA) begin
                        rr_cpu_next_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ack) begin
                    state_d   = ST_ACK;
                    mem_req_d = 1'b0;
                    if (!mem_wr_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_VGA;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_bytesel_q <= '0;
            rdata_q       <= '0;
            run_q         <= '0;
            rr_cpu_next_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_bytesel_q <= mem_bytesel_d;
            rdata_q       <= rdata_d;
            run_q         <= run_d;
            rr_cpu_next_q <= rr_cpu_next_d;
        end
    end

    // Acks decode straight from state so reset clears them immediately.
    assign bus.vga_ack     = (state_q == ST_ACK) && (owner_q == OWN_VGA);
    assign bus.cpu_ack     = (state_q == ST_ACK) && (owner_q == OWN_CPU);
    assign bus.dma_ack     = (state_q == ST_ACK) && (owner_q == OWN_DMA);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rdata       = rdata_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_bytesel = mem_bytesel_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed, table-driven bench for sdram_port_arbiter.
// Requesters are modelled as target/served counters: a requester's req is
// high while it has unserved transactions. A memory responder acks after a
// programmable number of cycles.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    typedef struct {
        owner_t      own;
        logic        wr;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [1:0]  bsel;
        int          dly;
        logic [15:0] rd_in;
        logic [15:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset_in = 1'b0;

    sdram_port_arbiter_if #(.addr_width(24)) bus ();

    sdram_port_arbiter #(
        .addr_width  (24),
        .vga_max_run (4)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int unsigned vga_tgt = 0, cpu_tgt = 0, dma_tgt = 0;
    int unsigned vga_got = 0, cpu_got = 0, dma_got = 0;
    int          ack_log[$];
    int          multi_ack = 0;

    int          ack_dly = 1;
    logic        resp_en = 1'b1;
    logic [15:0] resp_data = '0;

    int tests = 0;
    int failed = 0;

    assign bus.vga_req = (vga_tgt != vga_got);
    assign bus.cpu_req = (cpu_tgt != cpu_got);
    assign bus.dma_req = (dma_tgt != dma_got);

    // Ack monitor: records grant order and marks transactions served.
    initial begin
        forever begin
            @(negedge clk);
            if ((32'(bus.vga_ack) + 32'(bus.cpu_ack) + 32'(bus.dma_ack)) > 1) multi_ack++;
            if (bus.vga_ack) begin vga_got++; ack_log.push_back(0); end
            if (bus.cpu_ack) begin cpu_got++; ack_log.push_back(1); end
            if (bus.dma_ack) begin dma_got++; ack_log.push_back(2); end
        end
    end

    // Memory responder: single-cycle mem_ack after ack_dly cycles of mem_req.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (resp_en && bus.mem_req) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = resp_data;
                    cnt = 0;
                end
            end else if (!bus.mem_req) begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_in = 1'b0;
        step();
        step();
        reset_in = 1'b1;
        step();
    endtask

    task automatic wait_acks(input int unsigned n, input int limit, output int k);
        k = 0;
        while (ack_log.size() < n && k < limit) begin
            step();
            k++;
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int k;
        int unsigned base;
        case (v.own)
            OWN_VGA: begin
                bus.vga_wr = v.wr; bus.vga_addr = v.addr;
                bus.vga_wdata = v.wdata; bus.vga_bytesel = v.bsel;
            end
            OWN_CPU: begin
                bus.cpu_wr = v.wr; bus.cpu_addr = v.addr;
                bus.cpu_wdata = v.wdata; bus.cpu_bytesel = v.bsel;
            end
            default: begin
                bus.dma_wr = v.wr; bus.dma_addr = v.addr;
                bus.dma_wdata = v.wdata; bus.dma_bytesel = v.bsel;
            end
        endcase
        resp_data = v.rd_in;
        ack_dly   = v.dly;
        base      = ack_log.size();
        case (v.own)
            OWN_VGA: vga_tgt++;
            OWN_CPU: cpu_tgt++;
            default: dma_tgt++;
        endcase

        k = 0;
        while (!bus.mem_req && k < 50) begin
            step();
            k++;
        end
        chk({tag, "_memreq"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_memwr"}, 32'(bus.mem_wr), 32'(v.wr));
        chk({tag, "_memaddr"}, 32'(bus.mem_addr), 32'(v.addr));
        chk({tag, "_memwdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
        chk({tag, "_membsel"}, 32'(bus.mem_bytesel), 32'(v.bsel));
        chk({tag, "_busy_issue"}, 32'(bus.busy), 32'd1);

        wait_acks(base + 1, 50, k);
        chk({tag, "_latency"}, 32'(k), 32'(v.dly));
        if (ack_log.size() > base) chk({tag, "_owner"}, 32'(ack_log[base]), 32'(v.own));
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'(v.exp_rdata));
        chk({tag, "_memreq_drop"}, 32'(bus.mem_req), 32'd0);
        step();
        chk({tag, "_ack_pulse"}, 32'(ack_log.size()), 32'(base + 1));
        chk({tag, "_acks_low"}, {29'd0, bus.vga_ack, bus.cpu_ack, bus.dma_ack}, 32'd0);
        chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int k;
        int hi;
        int unsigned base;
        int exp_alt[8];
        int exp_run[10];
        vec_t v;

        vecs[0] = '{OWN_CPU, 1'b0, 24'h000123, 16'h0000, 2'b11, 3, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{OWN_DMA, 1'b1, 24'h00ABCD, 16'h55AA, 2'b01, 2, 16'h1111, 16'hBEEF};
        vecs[2] = '{OWN_VGA, 1'b0, 24'hFFFFFF, 16'h0000, 2'b11, 1, 16'h1234, 16'h1234};
        vecs[3] = '{OWN_VGA, 1'b1, 24'h000000, 16'h0000, 2'b10, 5, 16'hDEAD, 16'h1234};
        vecs[4] = '{OWN_DMA, 1'b0, 24'h800000, 16'h0000, 2'b11, 1, 16'hA5A5, 16'hA5A5};
        vecs[5] = '{OWN_CPU, 1'b1, 24'h7FFFFF, 16'hFFFF, 2'b11, 4, 16'h0000, 16'hA5A5};
        exp_alt = '{1, 2, 1, 2, 1, 2, 1, 2};
        exp_run = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        bus.pausecpu = 1'b0;   bus.pausevga = 1'b0;
        bus.vga_wr = 1'b0; bus.vga_addr = '0; bus.vga_wdata = '0; bus.vga_bytesel = '0;
        bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_bytesel = '0;
        bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_bytesel = '0;

        // Reset state.
        reset_in = 1'b0;
        step();
        chk("rst_memreq", 32'(bus.mem_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_memaddr", 32'(bus.mem_addr), 32'd0);
        chk("rst_memfields", {15'd0, bus.mem_wr, bus.mem_wdata}, 32'd0);
        chk("rst_acks", {29'd0, bus.vga_ack, bus.cpu_ack, bus.dma_ack}, 32'd0);
        step();
        reset_in = 1'b1;
        step();

        // Single transactions from the vector table.
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // CPU and DMA together: round robin starting with CPU after reset.
        do_reset();
        base = ack_log.size();
        ack_dly = 1;
        cpu_tgt += 4;
        dma_tgt += 4;
        wait_acks(base + 8, 200, k);
        chk("rr_count", 32'(ack_log.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (ack_log.size() > base + i)
                chk($sformatf("rr_order%0d", i), 32'(ack_log[base + i]), 32'(exp_alt[i]));
        end

        // VGA held with CPU pending: four VGA grants then one CPU.
        do_reset();
        base = ack_log.size();
        vga_tgt += 8;
        cpu_tgt += 2;
        wait_acks(base + 10, 300, k);
        chk("run_count", 32'(ack_log.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (ack_log.size() > base + i)
                chk($sformatf("run_order%0d", i), 32'(ack_log[base + i]), 32'(exp_run[i]));
        end

        // pausecpu blocks grants; release grants on the next edge; a pause
        // re-asserted mid-transaction does not abort it.
        do_reset();
        base = ack_log.size();
        ack_dly = 3;
        bus.pausecpu = 1'b1;
        cpu_tgt++;
        hi = 0;
        repeat (100) begin
            step();
            if (bus.mem_req) hi++;
        end
        chk("pause_no_memreq", 32'(hi), 32'd0);
        bus.pausecpu = 1'b0;
        step();
        chk("pause_release_grant", 32'(bus.mem_req), 32'd1);
        bus.pausecpu = 1'b1;
        wait_acks(base + 1, 50, k);
        chk("pause_mid_ack", 32'(ack_log.size() - base), 32'd1);
        if (ack_log.size() > base) chk("pause_mid_owner", 32'(ack_log[base]), 32'(OWN_CPU));
        bus.pausecpu = 1'b0;
        step();

        // Reset in the middle of ISSUE abandons the transaction.
        do_reset();
        resp_en = 1'b0;
        dma_tgt++;
        k = 0;
        while (!bus.mem_req && k < 50) begin
            step();
            k++;
        end
        chk("rstmid_issue", 32'(bus.mem_req), 32'd1);
        step();
        reset_in = 1'b0;
        #1;
        chk("rstmid_memreq", 32'(bus.mem_req), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_memaddr", 32'(bus.mem_addr), 32'd0);
        dma_tgt = dma_got;
        step();
        step();
        reset_in = 1'b1;
        resp_en  = 1'b1;
        base = ack_log.size();
        hi = 0;
        repeat (10) begin
            step();
            if (bus.mem_req) hi++;
        end
        chk("rstmid_no_ack", 32'(ack_log.size()), 32'(base));
        chk("rstmid_no_memreq", 32'(hi), 32'd0);
        v = '{OWN_CPU, 1'b0, 24'h000042, 16'h0000, 2'b11, 2, 16'h0F0F, 16'h0F0F};
        do_txn(v, "post_rst");

        chk("one_ack_per_cycle", 32'(multi_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
